// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the memory bus controller: access sizes, FSM states,
// timeout counter width and the alignment legality check.
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  // TIMEOUT_CYCLES must fit in this many bits.
  localparam int TO_CNT_W = 16;

  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: access_bad = 1'b0;
      SIZE_HALF: access_bad = addr_lo[0];
      SIZE_WORD: access_bad = (addr_lo != 2'b00);
      default:   access_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store-side enables/replication and load-side lane
// select with sign/zero extension.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] bus_wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    byte_en_o   = 4'b1111;
    bus_wdata_o = wdata_i;
    load_data_o = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        byte_en_o   = 4'b0001 << addr_lo_i;
        bus_wdata_o = {4{wdata_i[7:0]}};
        load_data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        byte_en_o   = 4'b0011 << addr_lo_i;
        bus_wdata_o = {2{wdata_i[15:0]}};
        load_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_controller.sv
// Single-outstanding memory access controller: latches a request, runs a
// wait-state bus cycle with timeout, and returns a one-cycle data or error pulse.
module mem_bus_controller
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        pClk,
  input  logic        pResetN,
  input  logic        pReqValid,
  output logic        pReqReady,
  input  logic        pReqWrite,
  input  logic [31:0] pReqAddr,
  input  logic [31:0] pReqWData,
  input  logic [1:0]  pReqSize,
  input  logic        pReqUnsigned,
  output logic [31:0] pRspData,
  output logic        pDataValid,
  output logic        pRspError,
  output logic [31:0] pBusAddr,
  output logic        pBusRead,
  output logic        pBusWrite,
  output logic [3:0]  pBusByteEn,
  output logic [31:0] pBusWData,
  input  logic [31:0] pBusRData,
  input  logic        pBusAck
);

  state_e              state_q, state_d;
  logic                write_q, uns_q;
  logic [31:0]         addr_q, wdata_q, rdata_q;
  logic [1:0]          size_q;
  logic [TO_CNT_W-1:0] cnt_q;
  logic [3:0]          be;
  logic [31:0]         bus_wd, load_data;
  logic                in_req, to_hit;

  mem_lane_align u_align (
    .size_i      (size_q),
    .addr_lo_i   (addr_q[1:0]),
    .unsigned_i  (uns_q),
    .wdata_i     (wdata_q),
    .rdata_i     (pBusRData),
    .byte_en_o   (be),
    .bus_wdata_o (bus_wd),
    .load_data_o (load_data)
  );

  assign in_req = (state_q == ST_REQ);
  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pReqValid) state_d = access_bad(pReqSize, pReqAddr[1:0]) ? ST_ERR : ST_REQ;
      // A late ack in the expiry cycle still completes the access.
      ST_REQ:  if (pBusAck) state_d = ST_RESP;
               else if (to_hit) state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pClk or negedge pResetN) begin
    if (!pResetN) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_BYTE;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pReqValid) begin
        write_q <= pReqWrite;
        uns_q   <= pReqUnsigned;
        addr_q  <= pReqAddr;
        wdata_q <= pReqWData;
        size_q  <= pReqSize;
      end
      cnt_q <= in_req ? cnt_q + 1'b1 : '0;
      if (in_req && pBusAck) rdata_q <= write_q ? 32'h0 : load_data;
    end
  end

  // Bus outputs are forced to zero outside REQ so reset and idle look identical.
  assign pReqReady  = (state_q == ST_IDLE);
  assign pDataValid = (state_q == ST_RESP);
  assign pRspError  = (state_q == ST_ERR);
  assign pRspData   = rdata_q;
  assign pBusRead   = in_req & ~write_q;
  assign pBusWrite  = in_req & write_q;
  assign pBusAddr   = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign pBusByteEn = in_req ? be : 4'b0000;
  assign pBusWData  = (in_req && write_q) ? bus_wd : 32'h0;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed bench for mem_bus_controller: stimulus pushes expected responses,
// a negedge monitor pops and checks every data/error pulse and its timing.
module tb_mem_bus_controller;

  localparam int TO = 4;

  logic        pClk = 1'b0;
  logic        pResetN;
  logic        pReqValid, pReqReady, pReqWrite, pReqUnsigned;
  logic [31:0] pReqAddr, pReqWData, pRspData, pBusAddr, pBusWData, pBusRData;
  logic [1:0]  pReqSize;
  logic        pDataValid, pRspError, pBusRead, pBusWrite, pBusAck;
  logic [3:0]  pBusByteEn;

  mem_bus_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .pClk(pClk), .pResetN(pResetN),
    .pReqValid(pReqValid), .pReqReady(pReqReady), .pReqWrite(pReqWrite),
    .pReqAddr(pReqAddr), .pReqWData(pReqWData), .pReqSize(pReqSize),
    .pReqUnsigned(pReqUnsigned), .pRspData(pRspData), .pDataValid(pDataValid),
    .pRspError(pRspError), .pBusAddr(pBusAddr), .pBusRead(pBusRead),
    .pBusWrite(pBusWrite), .pBusByteEn(pBusByteEn), .pBusWData(pBusWData),
    .pBusRData(pBusRData), .pBusAck(pBusAck)
  );

  always #5 pClk = ~pClk;

  int cyc = 0;
  always @(posedge pClk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(negedge pClk) begin
    if (pResetN === 1'b1 && (pDataValid || pRspError)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp dv=%b err=%b data=%h cyc=%0d", pDataValid, pRspError, pRspData, cyc);
      end else begin
        m_e = exp_q.pop_front();
        if (pRspError !== m_e.err || pDataValid !== !m_e.err ||
            (!m_e.err && pRspData !== m_e.data) || cyc != m_e.at) begin
          failures++;
          $display("FAIL rsp actual dv=%b err=%b data=%h cyc=%0d expected err=%b data=%h cyc=%0d",
                   pDataValid, pRspError, pRspData, cyc, m_e.err, m_e.data, m_e.at);
        end
      end
    end
  end

  // waits < 0 means the bus never acks; bus=0 means no bus cycle is expected.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns, input logic [31:0] rd,
                        input int waits, input logic bus, input logic [3:0] xbe,
                        input logic [31:0] xwd, input logic xerr, input logic [31:0] xdata);
    exp_t e;
    int acc, lat, ncyc;
    @(negedge pClk);
    chk("req_ready", 32'(pReqReady), 32'd1);
    pReqValid = 1'b1; pReqWrite = wr; pReqAddr = addr; pReqWData = wd;
    pReqSize = sz; pReqUnsigned = uns;
    @(posedge pClk); #1;
    acc = cyc;
    pReqValid = 1'b0;
    // Latency counted in clock edges after the accepting edge.
    lat = !bus ? 0 : (waits < 0 ? TO : waits + 1);
    e.err = xerr; e.data = xdata; e.at = acc + lat;
    exp_q.push_back(e);
    if (bus) begin
      ncyc = (waits < 0) ? TO : waits + 1;
      for (int k = 0; k < ncyc; k++) begin
        @(negedge pClk);
        chk("strobe", 32'({pBusRead, pBusWrite}), wr ? 32'd1 : 32'd2);
        chk("bus_addr", pBusAddr, {addr[31:2], 2'b00});
        chk("byte_en", 32'(pBusByteEn), 32'(xbe));
        chk("bus_wdata", pBusWData, wr ? xwd : 32'h0);
        if (k == waits) begin
          pBusAck = 1'b1; pBusRData = rd;
          @(posedge pClk); #1;
          pBusAck = 1'b0; pBusRData = 32'h0;
        end
      end
    end
    @(negedge pClk);
    chk("strobe_off", 32'({pBusRead, pBusWrite}), 32'd0);
    @(posedge pClk); #1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge pClk);
    if (exp_q.size() != 0) begin
      chk("rsp_missing", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    pResetN = 1'b0; pReqValid = 1'b0; pReqWrite = 1'b0; pReqAddr = '0;
    pReqWData = '0; pReqSize = 2'b00; pReqUnsigned = 1'b0;
    pBusRData = '0; pBusAck = 1'b0;
    #3;
    chk("rst_ready", 32'(pReqReady), 32'd1);
    chk("rst_dv_err", 32'({pDataValid, pRspError}), 32'd0);
    chk("rst_strobes", 32'({pBusRead, pBusWrite}), 32'd0);
    chk("rst_be", 32'(pBusByteEn), 32'd0);
    chk("rst_addr", pBusAddr, 32'h0);
    chk("rst_wdata", pBusWData, 32'h0);
    chk("rst_rdata", pRspData, 32'h0);
    repeat (2) @(negedge pClk);
    pResetN = 1'b1;

    //     wr    addr          wdata         sz     uns   rdata         waits bus  be       bus wdata     err   data
    do_req(1'b0, 32'h0000_1004, 32'h0,        2'b10, 1'b0, 32'hDEAD_BEEF, 0,  1'b1, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h0000_0103, 32'h0,        2'b00, 1'b0, 32'h80FF_0000, 1,  1'b1, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80);
    do_req(1'b0, 32'h0000_0103, 32'h0,        2'b00, 1'b1, 32'h80FF_0000, 0,  1'b1, 4'b1000, 32'h0,        1'b0, 32'h0000_0080);
    do_req(1'b1, 32'h0000_0102, 32'h0000_ABCD, 2'b01, 1'b0, 32'h1234_5678, 3,  1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);
    do_req(1'b0, 32'h0000_1002, 32'h0,        2'b10, 1'b0, 32'h0,        0,  1'b0, 4'b0000, 32'h0,        1'b1, 32'h0);
    do_req(1'b0, 32'h0000_2000, 32'h0,        2'b10, 1'b0, 32'h0,        -1, 1'b1, 4'b1111, 32'h0,        1'b1, 32'h0);
    do_req(1'b0, 32'h0000_2000, 32'h0,        2'b10, 1'b0, 32'hCAFE_F00D, 3,  1'b1, 4'b1111, 32'h0,        1'b0, 32'hCAFE_F00D);
    do_req(1'b0, 32'h0000_0002, 32'h0,        2'b01, 1'b0, 32'h8001_0000, 0,  1'b1, 4'b1100, 32'h0,        1'b0, 32'hFFFF_8001);
    do_req(1'b0, 32'h0000_0000, 32'h0,        2'b01, 1'b1, 32'h0000_F00F, 0,  1'b1, 4'b0011, 32'h0,        1'b0, 32'h0000_F00F);
    do_req(1'b1, 32'h0000_0001, 32'h0000_005A, 2'b00, 1'b0, 32'h0,        1,  1'b1, 4'b0010, 32'h5A5A_5A5A, 1'b0, 32'h0);
    do_req(1'b1, 32'h0000_0010, 32'h1122_3344, 2'b10, 1'b0, 32'h0,        0,  1'b1, 4'b1111, 32'h1122_3344, 1'b0, 32'h0);
    do_req(1'b0, 32'h0000_0000, 32'h0,        2'b11, 1'b0, 32'h0,        0,  1'b0, 4'b0000, 32'h0,        1'b1, 32'h0);
    do_req(1'b0, 32'h0000_0005, 32'h0,        2'b01, 1'b0, 32'h0,        0,  1'b0, 4'b0000, 32'h0,        1'b1, 32'h0);

    // Reset in the middle of a bus cycle: no response may follow.
    @(negedge pClk);
    pReqValid = 1'b1; pReqWrite = 1'b0; pReqAddr = 32'h0000_3000; pReqSize = 2'b10;
    @(posedge pClk); #1;
    pReqValid = 1'b0;
    @(negedge pClk);
    @(negedge pClk);
    chk("mid_req_strobe", 32'(pBusRead), 32'd1);
    pResetN = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({pBusRead, pBusWrite}), 32'd0);
    chk("mid_rst_ready", 32'(pReqReady), 32'd1);
    chk("mid_rst_be", 32'(pBusByteEn), 32'd0);
    @(negedge pClk);
    pResetN = 1'b1;
    repeat (8) @(negedge pClk);
    chk("post_rst_ready", 32'(pReqReady), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
